ifetch_buffer: RTL

- Instruction fetch buffer between the IFU and the decode stage.
- Captures each completed fetch (instruction word plus its PC) into a DEPTH-entry circular queue.
- Presents the oldest entry to decode under a valid/ready handshake.
- Drives a stall request back to the IFU control word when nearly full, and discards everything on a redirect flush.

---
 rtl/ifetch_buffer.sv | 101 ++++++++++
 1 files changed

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: a DEPTH-entry circular queue of {pc, instr} pairs
// between the IFU and decode, with first-word fall-through output and a near-full stall.
module ifetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        fetch_instr,
    input  logic [ADDR_W-1:0]        fetch_pc,
    input  logic                     fetch_complete,
    input  logic                     flush,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [DATA_W-1:0]        dec_instr,
    output logic [ADDR_W-1:0]        dec_pc,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a head entry transfers to decode on a rising edge where
    // dec_valid && dec_ready; dec_valid never depends on dec_ready.

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             stall_q,  stall_d;
    logic             ovf_q,    ovf_d;

    logic full, push_en, pop_en;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        pop_en   = (count_q != '0) && dec_ready && !flush;
        push_en  = fetch_complete && !full && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // A full queue rejects the push even when a pop frees a slot this cycle.
            if (fetch_complete && full) begin
                ovf_d = 1'b1;
            end
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
        stall_d = (count_d >= CNT_W'(DEPTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            instr_mem_q[wr_ptr_q] <= fetch_instr;
            pc_mem_q[wr_ptr_q]    <= fetch_pc;
        end
    end

    always_comb begin
        dec_valid    = (count_q != '0);
        dec_instr    = dec_valid ? instr_mem_q[rd_ptr_q] : '0;
        dec_pc       = dec_valid ? pc_mem_q[rd_ptr_q] : '0;
        stall_req    = stall_q;
        occupancy    = count_q;
        overflow_err = ovf_q;
    end

endmodule
